// File: rtl/gb_lcd_capture.sv
// Game Boy LCD bus capture: synchronises the raw GB LCD signals into CLK_25MHz and turns them
// into linear framebuffer write strobes, frame/line status pulses and an LCD-on level.
module gb_lcd_capture #(
   parameter int unsigned H_PIXELS       = 160,
   parameter int unsigned V_PIXELS       = 144,
   parameter int unsigned ADDR_W         = 15,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic              CLK_25MHz,
   input  logic              RST_N,
   input  logic [1:0]        GB_DAT,
   input  logic              GB_HSYNC,
   input  logic              GB_VSYNC,
   input  logic              GB_PX_CLK,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_data,
   output logic              frame_start,
   output logic              frame_done,
   output logic              line_err,
   output logic              lcd_on
);

   localparam int unsigned     ToW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]      HLim   = 8'(H_PIXELS);
   localparam logic [7:0]      VLim   = 8'(V_PIXELS);
   localparam logic [7:0]      CntOne = 8'd1;
   localparam logic [ADDR_W-1:0] HStep   = ADDR_W'(H_PIXELS);
   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
   localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT_CYCLES);
   localparam logic [ToW-1:0]  ToLast = ToW'(TIMEOUT_CYCLES - 1);
   localparam logic [ToW-1:0]  ToOne  = ToW'(1);

   typedef enum logic [1:0] {StLcdOff, StWaitFrame, StCapture} state_e;

   // [0],[1] are the synchroniser, [2] is the edge-detect history; VSYNC and data are only
   // used as levels, so they stop at the second stage but stay aligned with the clock path.
   logic [2:0] px_sync_q, hs_sync_q;
   logic [1:0] vs_sync_q;
   logic [1:0] dat_s1_q, dat_s2_q;

   state_e            state_q;
   logic [7:0]        x_cnt_q, y_cnt_q;
   logic [ADDR_W-1:0] addr_cnt_q, line_base_q;
   logic              ovr_q;
   logic [ToW-1:0]    to_cnt_q;
   logic              lcd_on_q, wr_en_q, frame_start_q, frame_done_q, line_err_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [1:0]        wr_data_q;

   logic              px_fall, hs_rise, vs_now;
   logic              line_evt, restart, pix_ok, last_px, timeout;
   logic [7:0]        x_ln, y_ln;
   logic [ADDR_W-1:0] addr_ln, base_ln;

   always_ff @(posedge CLK_25MHz or negedge RST_N) begin
      if (!RST_N) begin
         px_sync_q <= '0;
         hs_sync_q <= '0;
         vs_sync_q <= '0;
         dat_s1_q  <= '0;
         dat_s2_q  <= '0;
      end else begin
         px_sync_q <= {px_sync_q[1:0], GB_PX_CLK};
         hs_sync_q <= {hs_sync_q[1:0], GB_HSYNC};
         vs_sync_q <= {vs_sync_q[0], GB_VSYNC};
         dat_s1_q  <= GB_DAT;
         dat_s2_q  <= dat_s1_q;
      end
   end

   assign px_fall = px_sync_q[2] & ~px_sync_q[1];
   assign hs_rise = hs_sync_q[1] & ~hs_sync_q[2];
   assign vs_now  = vs_sync_q[1];

   // Line event is resolved first so a pixel arriving in the same cycle lands at x=0.
   always_comb begin
      line_evt = hs_rise && ((state_q == StWaitFrame && vs_now) || state_q == StCapture);
      restart  = line_evt && vs_now;
      x_ln     = x_cnt_q;
      y_ln     = y_cnt_q;
      addr_ln  = addr_cnt_q;
      base_ln  = line_base_q;
      if (restart) begin
         x_ln    = '0;
         y_ln    = '0;
         addr_ln = '0;
         base_ln = '0;
      end else if (line_evt) begin
         x_ln    = '0;
         y_ln    = y_cnt_q + CntOne;
         base_ln = line_base_q + HStep;
         addr_ln = line_base_q + HStep;
      end
      pix_ok  = px_fall && (state_q == StCapture || line_evt) && (x_ln < HLim) && (y_ln < VLim);
      last_px = (x_ln == HLim - CntOne) && (y_ln == VLim - CntOne);
      timeout = (to_cnt_q == ToLast) && !px_fall;
   end

   always_ff @(posedge CLK_25MHz or negedge RST_N) begin
      if (!RST_N) begin
         state_q       <= StLcdOff;
         x_cnt_q       <= '0;
         y_cnt_q       <= '0;
         addr_cnt_q    <= '0;
         line_base_q   <= '0;
         ovr_q         <= 1'b0;
         to_cnt_q      <= '0;
         lcd_on_q      <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         line_err_q    <= 1'b0;
      end else begin
         wr_en_q       <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         line_err_q    <= 1'b0;

         if (px_fall) begin
            to_cnt_q <= '0;
         end else if (to_cnt_q != ToMax) begin
            to_cnt_q <= to_cnt_q + ToOne;
         end

         if (timeout) begin
            state_q  <= StLcdOff;
            lcd_on_q <= 1'b0;
         end else begin
            unique case (state_q)
               StLcdOff: begin
                  if (px_fall) begin
                     lcd_on_q <= 1'b1;
                     state_q  <= StWaitFrame;
                  end
               end
               StWaitFrame, StCapture: begin
                  if (line_evt) begin
                     line_err_q    <= (state_q == StCapture) && ((x_cnt_q != HLim) || ovr_q);
                     ovr_q         <= 1'b0;
                     x_cnt_q       <= x_ln;
                     y_cnt_q       <= y_ln;
                     addr_cnt_q    <= addr_ln;
                     line_base_q   <= base_ln;
                     frame_start_q <= restart;
                     state_q       <= StCapture;
                  end
                  if (px_fall && (state_q == StCapture || line_evt)) begin
                     if (pix_ok) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= addr_ln;
                        wr_data_q  <= dat_s2_q;
                        x_cnt_q    <= x_ln + CntOne;
                        addr_cnt_q <= addr_ln + AddrOne;
                        if (last_px) begin
                           frame_done_q <= 1'b1;
                           state_q      <= StWaitFrame;
                        end
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= StLcdOff;
            endcase
         end
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign line_err    = line_err_q;
   assign lcd_on      = lcd_on_q;

endmodule
